adc_spi_responder: RTL and testbench

- Synthesizable responder (ADC-side) model of the 3-wire serial ADC link driven by the team's ADC controller: 8 channels, 12-bit samples, 16-SCLK frames.
- Oversamples CS_n/SCLK/DIN on the fabric clock, decodes the 3-bit channel address, and shifts the sample out on DOUT MSB-first.
- Used for on-board loopback and bench verification of the ADC controller and downstream VPPM receiver, with no physical ADC in the loop.

---
 rtl/adc_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 36 +++
 rtl/adc_spi_responder.sv | 180 ++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and state type for the serial ADC responder.
package adc_pkg;

  localparam int ADC_DATA_W     = 12;
  localparam int ADC_N_CH       = 8;
  localparam int ADC_FRAME_LEN  = 16;
  localparam int ADC_LEAD_ZEROS = 4;
  localparam int ADC_ADDR_FIRST = 2;
  localparam int ADC_ADDR_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } respState_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by one edge-detect flop; reports the
// synchronized level and single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iD,
  output logic oLEVEL,
  output logic oRISE,
  output logic oFALL
);

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   prevReg;

  // NOTE: non-blocking assignments so each stage samples its predecessor's old value.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      syncReg <= {SYNC_STAGES{RESET_VAL}};
      prevReg <= RESET_VAL;
    end else begin
      syncReg[0] <= iD;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncReg[i] <= syncReg[i-1];
      end
      prevReg <= syncReg[SYNC_STAGES-1];
    end
  end

  assign oLEVEL = syncReg[SYNC_STAGES-1];
  assign oRISE  = syncReg[SYNC_STAGES-1] & ~prevReg;
  assign oFALL  = ~syncReg[SYNC_STAGES-1] & prevReg;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side responder for the 3-wire serial ADC link: decodes the channel address
// on DIN and returns 4 zeros + sample MSB-first on DOUT. Macro ADC_RESP_ERR_EN adds oERR_CNT.
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int N_CH        = ADC_N_CH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iCS_n,
  input  logic                   iSCLK,
  input  logic                   iDIN,
  input  logic [N_CH*DATA_W-1:0] iSAMPLES,
  output logic                   oDOUT,
  output logic [ADC_ADDR_W-1:0]  oCH,
  output logic                   oFRAME_DONE,
  output logic                   oBUSY
`ifdef ADC_RESP_ERR_EN
  ,
  output logic [7:0]             oERR_CNT
`endif
);

  localparam int FRAME_LEN = ADC_LEAD_ZEROS + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_A2   = CNT_W'(ADC_ADDR_FIRST);
  localparam logic [CNT_W-1:0] CNT_A1   = CNT_W'(ADC_ADDR_FIRST + 1);
  localparam logic [CNT_W-1:0] CNT_A0   = CNT_W'(ADC_ADDR_FIRST + 2);

  logic csLevel, csRise, csFall;
  logic sclkLevel, sclkRise, sclkFall;
  logic dinLevel, dinRise, dinFall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uCsSync (
    .iCLK(iCLK), .iRST(iRST), .iD(iCS_n),
    .oLEVEL(csLevel), .oRISE(csRise), .oFALL(csFall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSclkSync (
    .iCLK(iCLK), .iRST(iRST), .iD(iSCLK),
    .oLEVEL(sclkLevel), .oRISE(sclkRise), .oFALL(sclkFall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uDinSync (
    .iCLK(iCLK), .iRST(iRST), .iD(iDIN),
    .oLEVEL(dinLevel), .oRISE(dinRise), .oFALL(dinFall)
  );

  // Only the edges of CS_n/SCLK and the level of DIN drive the protocol.
  logic unusedOk;
  assign unusedOk = &{1'b0, csLevel, sclkLevel, dinRise, dinFall};

  logic [DATA_W-1:0] sampleArr [N_CH];

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      sampleArr[k] = iSAMPLES[k*DATA_W +: DATA_W];
    end
  end

  respState_t            stateReg, stateNext;
  logic [CNT_W-1:0]      cntReg, cntNext;
  logic [FRAME_LEN-1:0]  shiftReg, shiftNext;
  logic [FRAME_LEN-1:0]  loadWord;
  logic                  doutReg, doutNext;
  logic [ADC_ADDR_W-1:0] chReg, chNext;
  logic [1:0]            addrReg, addrNext;
  logic                  busyReg, busyNext;
  logic                  doneReg, doneNext;

  assign loadWord = {{ADC_LEAD_ZEROS{1'b0}}, sampleArr[chReg]};

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      shiftReg <= '0;
      doutReg  <= 1'b0;
      chReg    <= '0;
      addrReg  <= '0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      shiftReg <= shiftNext;
      doutReg  <= doutNext;
      chReg    <= chNext;
      addrReg  <= addrNext;
      busyReg  <= busyNext;
      doneReg  <= doneNext;
    end
  end

  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    shiftNext = shiftReg;
    doutNext  = doutReg;
    chNext    = chReg;
    addrNext  = addrReg;
    busyNext  = busyReg;
    doneNext  = 1'b0;

    if (csRise) begin
      // Deselect wins over a coincident SCLK edge; a partial address is dropped.
      stateNext = IDLE;
      cntNext   = '0;
      doutNext  = 1'b0;
      busyNext  = 1'b0;
    end else begin
      unique case (stateReg)
        IDLE: begin
          if (csFall) stateNext = LOAD;
        end
        LOAD: begin
          shiftNext = loadWord;
          doutNext  = 1'b0;
          busyNext  = 1'b1;
          stateNext = SHIFT;
        end
        SHIFT: begin
          if (sclkRise) begin
            cntNext  = (cntReg == CNT_LAST) ? '0 : cntReg + 1'b1;
            doneNext = (cntReg == CNT_LAST);
            if (cntReg == CNT_A2) addrNext[1] = dinLevel;
            if (cntReg == CNT_A1) addrNext[0] = dinLevel;
            if (cntReg == CNT_A0) chNext = {addrReg, dinLevel};
          end else if (sclkFall) begin
            // Counter at zero means frame start or just wrapped: fetch a fresh word.
            if (cntReg == '0) begin
              shiftNext = loadWord;
              doutNext  = loadWord[FRAME_LEN-1];
            end else begin
              shiftNext = {shiftReg[FRAME_LEN-2:0], 1'b0};
              doutNext  = shiftReg[FRAME_LEN-2];
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign oDOUT       = doutReg;
  assign oCH         = chReg;
  assign oFRAME_DONE = doneReg;
  assign oBUSY       = busyReg;

`ifdef ADC_RESP_ERR_EN
  logic [7:0] errCntReg;
  logic [1:0] gapReg;
  logic       sclkEdge, shortFrame, fastEdge;

  assign sclkEdge   = sclkRise | sclkFall;
  assign shortFrame = csRise && (cntReg != '0);
  // gapReg saturates at 3, so a value below 3 means the previous edge was < 4 cycles ago.
  assign fastEdge   = sclkEdge && (gapReg != 2'd3) && (stateReg != IDLE);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      errCntReg <= '0;
      gapReg    <= 2'd3;
    end else begin
      if (sclkEdge)            gapReg <= 2'd0;
      else if (gapReg != 2'd3) gapReg <= gapReg + 1'b1;
      if ((shortFrame || fastEdge) && (errCntReg != 8'hFF)) begin
        errCntReg <= errCntReg + 1'b1;
      end
    end
  end

  assign oERR_CNT = errCntReg;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench: a controller-style driver plus a frame-level reference model.
module tb_adc_spi_responder;
  import adc_pkg::*;

  localparam int DW = ADC_DATA_W;
  localparam int NC = ADC_N_CH;

  logic           iCLK = 1'b0;
  logic           iRST = 1'b1;
  logic           iCS_n = 1'b1;
  logic           iSCLK = 1'b1;
  logic           iDIN = 1'b0;
  logic [NC*DW-1:0] iSAMPLES = '0;
  logic           oDOUT;
  logic [2:0]     oCH;
  logic           oFRAME_DONE;
  logic           oBUSY;
`ifdef ADC_RESP_ERR_EN
  logic [7:0]     oERR_CNT;
`endif

  int checks = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  adc_spi_responder dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .iCS_n(iCS_n),
    .iSCLK(iSCLK),
    .iDIN(iDIN),
    .iSAMPLES(iSAMPLES),
    .oDOUT(oDOUT),
    .oCH(oCH),
    .oFRAME_DONE(oFRAME_DONE),
    .oBUSY(oBUSY)
`ifdef ADC_RESP_ERR_EN
    ,
    .oERR_CNT(oERR_CNT)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] smp(input logic [NC*DW-1:0] t, input int k);
    return t[k*DW +: DW];
  endfunction

  // Reference model: tracks the pins as the controller sees them, frame by frame.
  logic        prevCs = 1'b1, prevSclk = 1'b1, prevRst = 1'b0;
  int          bitIdx = 0;
  logic [2:0]  modelCh = '0;
  logic [2:0]  modelAddr = '0;
  logic [15:0] expWord = '0;
  int          expDone = 0, doneCount = 0, settle = 0, expErr = 0;

  always @(negedge iCLK) begin
    if (iRST) begin
      bitIdx  = 0;
      modelCh = '0;
      expErr  = 0;
      settle  = 7;
      if (prevRst) begin
        check("rst_dout", oDOUT, 0);
        check("rst_ch", oCH, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_done", oFRAME_DONE, 0);
      end
    end else begin
      if (oFRAME_DONE) doneCount++;
      if (!prevCs && iCS_n) begin
        if (bitIdx != 0 && expErr < 255) expErr++;
        bitIdx = 0;
        settle = 1;
      end else if (!iCS_n && !prevSclk && iSCLK) begin
        check("dout_bit", oDOUT, expWord[15-bitIdx]);
        check("ch_frame", oCH, modelCh);
        check("busy_frame", oBUSY, 1);
        check("done_count", doneCount, expDone);
        if (bitIdx >= 2 && bitIdx <= 4) modelAddr[4-bitIdx] = iDIN;
        if (bitIdx == 4) modelCh = modelAddr;
        bitIdx++;
        if (bitIdx == 16) begin
          bitIdx = 0;
          expDone++;
        end
      end else if (!iCS_n && prevSclk && !iSCLK && bitIdx == 0) begin
        expWord = {4'b0, smp(iSAMPLES, int'(modelCh))};
      end
      if (iCS_n) begin
        if (settle > 0) settle++;
        if (settle > 6) begin
          check("idle_busy", oBUSY, 0);
          check("idle_dout", oDOUT, 0);
          check("idle_ch", oCH, modelCh);
          check("idle_done", doneCount, expDone);
`ifdef ADC_RESP_ERR_EN
          check("idle_err", oERR_CNT, expErr);
`endif
        end
      end
    end
    prevCs   = iCS_n;
    prevSclk = iSCLK;
    prevRst  = iRST;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #2;
  endtask

  // Controller: SCLK at iCLK/16, DIN changes on the falling edge, DOUT sampled just before each rise.
  task automatic runFrame(input logic [2:0] addr, input int nRise, input bit releaseCs,
                          input int rstAt, input int chgAt, input logic [NC*DW-1:0] chgTo,
                          output logic [15:0] word);
    word = '0;
    if (iCS_n) begin
      iCS_n = 1'b0;
      tick(8);
    end
    for (int r = 1; r <= nRise; r++) begin
      iSCLK = 1'b0;
      iDIN  = (r >= 3 && r <= 5) ? addr[5-r] : 1'($urandom_range(0, 1));
      tick(8);
      word[16-r] = oDOUT;
      if (r == rstAt) begin
        iRST  = 1'b1;
        iSCLK = 1'b1;
        @(posedge iCLK);
        #1;
        check("midrst_dout", oDOUT, 0);
        check("midrst_ch", oCH, 0);
        check("midrst_busy", oBUSY, 0);
        check("midrst_done", oFRAME_DONE, 0);
        iCS_n = 1'b1;
        tick(4);
        iRST = 1'b0;
        tick(4);
        return;
      end
      iSCLK = 1'b1;
      tick(8);
      if (r == chgAt) iSAMPLES = chgTo;
    end
    if (releaseCs) begin
      iCS_n = 1'b1;
      tick(12);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0]      w;
    logic [NC*DW-1:0] tbl, chg;
    int               mode, n;
    logic [2:0]       a;

    tick(5);
    iRST = 1'b0;
    check("init_dout", oDOUT, 0);
    check("init_ch", oCH, 0);
    check("init_busy", oBUSY, 0);
    tick(20);
    check("hold_dout", oDOUT, 0);
    check("hold_ch", oCH, 0);
    check("hold_busy", oBUSY, 0);

    for (int k = 0; k < NC; k++) tbl[k*DW +: DW] = DW'($urandom);
    tbl[0*DW +: DW] = 12'hA5C;
    tbl[5*DW +: DW] = 12'h3F1;
    iSAMPLES = tbl;
    runFrame(3'b101, 16, 1'b1, 0, 0, '0, w);
    check("f1_word", w, 16'h0A5C);
    check("f1_ch", oCH, 5);
    runFrame(3'b101, 16, 1'b1, 0, 0, '0, w);
    check("f2_word", w, 16'h03F1);

    // Continuous conversion with CS_n held low: first frame still returns ch5.
    for (int f = 0; f < 4; f++) begin
      runFrame(3'b010, 16, (f == 3), 0, 0, '0, w);
      check("cont_word", w, (f == 0) ? 16'h03F1 : {4'b0, smp(tbl, 2)});
    end
    check("cont_ch", oCH, 2);

    runFrame(3'b111, 3, 1'b1, 0, 0, '0, w);
    check("short_ch", oCH, 2);
    check("short_busy", oBUSY, 0);
`ifdef ADC_RESP_ERR_EN
    check("short_err", oERR_CNT, 1);
`endif

    runFrame(3'b011, 16, 1'b0, 9, 0, '0, w);
    runFrame(3'b000, 16, 1'b1, 0, 0, '0, w);
    check("post_rst_word", w, 16'h0A5C);

    tbl[0*DW +: DW] = 12'h001;
    iSAMPLES = tbl;
    chg = tbl;
    chg[0*DW +: DW] = 12'hFFF;
    runFrame(3'b000, 16, 1'b1, 0, 6, chg, w);
    check("chg_word", w, 16'h0001);
    runFrame(3'b000, 16, 1'b1, 0, 0, '0, w);
    check("chg_next_word", w, 16'h0FFF);

    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < NC; k++) tbl[k*DW +: DW] = DW'($urandom);
        iSAMPLES = tbl;
      end
      mode = $urandom_range(0, 2);
      a    = 3'($urandom_range(0, 7));
      if (mode == 0) begin
        runFrame(a, 16, 1'b1, 0, 0, '0, w);
      end else if (mode == 1) begin
        runFrame(a, $urandom_range(1, 15), 1'b1, 0, 0, '0, w);
      end else begin
        n = $urandom_range(2, 3);
        for (int f = 0; f < n; f++) begin
          runFrame(3'($urandom_range(0, 7)), 16, (f == n - 1), 0, 0, '0, w);
        end
      end
    end

    tick(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
